// File: rtl/mpq_cmd_seq.sv
// Stimulus sequencer for the max-priority-queue: preloads data/commands, streams data, then paces commands on busy.
// Optional watchdog on the wait states is enabled by defining MPQ_SEQ_TIMEOUT_EN.
module mpq_cmd_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 32,
    parameter int CMD_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_data_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_cmd_valid,
    input  logic [2:0]            ld_cmd,
    input  logic [7:0]            ld_index,
    input  logic [DATA_WIDTH-1:0] ld_value,
    input  logic                  start,
    output logic                  ld_ready,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  cmd_valid,
    output logic [2:0]            cmd,
    output logic [7:0]            index,
    output logic [DATA_WIDTH-1:0] value,
    input  logic                  busy,
    input  logic                  done,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic [2:0]            err_flags
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int DCW = DAW + 1;
    localparam int CCW = CAW + 1;

    typedef enum logic [2:0] {
        S_LOAD, S_STREAM, S_WAIT_RDY, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_FINISH
    } state_t;

    typedef struct packed {
        logic [2:0]            code;
        logic [7:0]            idx;
        logic [DATA_WIDTH-1:0] val;
    } cmd_t;

    logic [DATA_WIDTH-1:0] dbuf [DATA_DEPTH];
    cmd_t                  cbuf [CMD_DEPTH];

    state_t         state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d, drd_q, drd_d;
    logic [CCW-1:0] ccnt_q, ccnt_d, crd_q, crd_d;
    cmd_t           cur_q, cur_d;
    logic [2:0]     err_q, err_d;
    logic           dwr_en, cwr_en;

`ifdef MPQ_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_wait;
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        drd_d   = drd_q;
        ccnt_d  = ccnt_q;
        crd_d   = crd_q;
        cur_d   = cur_q;
        err_d   = err_q;
        dwr_en  = 1'b0;
        cwr_en  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (ld_data_valid) begin
                    if (dcnt_q == DCW'(DATA_DEPTH)) begin
                        err_d[0] = 1'b1;
                    end else begin
                        dwr_en = 1'b1;
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                if (ld_cmd_valid) begin
                    if (ccnt_q == CCW'(CMD_DEPTH)) begin
                        err_d[1] = 1'b1;
                    end else begin
                        cwr_en = 1'b1;
                        ccnt_d = ccnt_q + 1'b1;
                    end
                end
                // A word written alongside start is part of the stream.
                if (start) begin
                    state_d = (dcnt_d == '0) ? S_WAIT_RDY : S_STREAM;
                end
            end
            S_STREAM: begin
                drd_d = drd_q + 1'b1;
                if (drd_q == dcnt_q - 1'b1) begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!busy) begin
                    if (crd_q == ccnt_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                        cur_d   = cbuf[crd_q[CAW-1:0]];
                    end
                end
            end
            S_ISSUE: begin
                crd_d   = crd_q + 1'b1;
                state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (busy) begin
                    state_d = (cur_q.code == 3'd4) ? S_WAIT_DONE : S_WAIT_RDY;
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_d = S_FINISH;
                end
            end
            default: ;
        endcase

`ifdef MPQ_SEQ_TIMEOUT_EN
        // Counter restarts on every state change; expiry overrides the normal transition.
        in_wait = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_ACC) || (state_q == S_WAIT_DONE);
        tmo_d   = '0;
        if (in_wait && (state_d == state_q)) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d[2] = 1'b1;
                state_d  = S_FINISH;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            dcnt_q  <= '0;
            drd_q   <= '0;
            ccnt_q  <= '0;
            crd_q   <= '0;
            cur_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            drd_q   <= drd_d;
            ccnt_q  <= ccnt_d;
            crd_q   <= crd_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

`ifdef MPQ_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (dwr_en) begin
            dbuf[dcnt_q[DAW-1:0]] <= ld_data;
        end
        if (cwr_en) begin
            cbuf[ccnt_q[CAW-1:0]] <= '{code: ld_cmd, idx: ld_index, val: ld_value};
        end
    end

    assign ld_ready   = (state_q == S_LOAD);
    assign data_valid = (state_q == S_STREAM);
    assign data       = data_valid ? dbuf[drd_q[DAW-1:0]] : '0;
    assign cmd_valid  = (state_q == S_ISSUE);
    assign cmd        = cur_q.code;
    assign index      = cur_q.idx;
    assign value      = cur_q.val;
    assign seq_busy   = (state_q != S_LOAD) && (state_q != S_FINISH);
    assign seq_done   = (state_q == S_FINISH);
    assign err_flags  = err_q;

endmodule

// File: tb/tb_mpq_cmd_seq.sv
// Directed bench for mpq_cmd_seq with a small queue model that answers commands with busy/done.
module tb_mpq_cmd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_data_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_cmd_valid = 1'b0;
    logic [2:0] ld_cmd = '0;
    logic [7:0] ld_index = '0;
    logic [7:0] ld_value = '0;
    logic       start = 1'b0;
    logic       ld_ready, data_valid, cmd_valid, seq_busy, seq_done;
    logic [7:0] data, index, value;
    logic [2:0] cmd, err_flags;
    logic       busy = 1'b0;
    logic       done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       model_on = 1'b0;
    logic       busy_man = 1'b0;
    int         hold_len = 1;
    int         hold = 0;
    logic       pend = 1'b0;
    logic       pend_wr = 1'b0;
    int         viol = 0;

    logic [7:0] dlog[$];
    int         dcyc[$];
    logic [2:0] clog_c[$];
    logic [7:0] clog_i[$];
    logic [7:0] clog_v[$];

    mpq_cmd_seq #(
        .DATA_WIDTH(8), .DATA_DEPTH(4), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .ld_cmd_valid(ld_cmd_valid), .ld_cmd(ld_cmd), .ld_index(ld_index), .ld_value(ld_value),
        .start(start), .ld_ready(ld_ready),
        .data_valid(data_valid), .data(data),
        .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
        .busy(busy), .done(done),
        .seq_busy(seq_busy), .seq_done(seq_done), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            dlog.push_back(data);
            dcyc.push_back(cyc);
        end
        if (cmd_valid) begin
            clog_c.push_back(cmd);
            clog_i.push_back(index);
            clog_v.push_back(value);
            if (busy) viol++;
        end
    end

    // Queue model: busy rises the cycle after a command strobe, stays hold_len cycles,
    // and a write_RAM ends with a one-cycle done pulse.
    always @(posedge clk) begin
        #2;
        done = 1'b0;
        if (rst) begin
            hold    = 0;
            pend    = 1'b0;
            pend_wr = 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0 && pend_wr) begin
                    done    = 1'b1;
                    pend_wr = 1'b0;
                end
            end
            if (pend) begin
                hold = hold_len;
                pend = 1'b0;
            end
            if (cmd_valid && model_on) begin
                pend    = 1'b1;
                pend_wr = (cmd == 3'd4);
            end
        end
        busy = (hold > 0) ? 1'b1 : busy_man;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_data_valid = 1'b0;
        ld_cmd_valid = 1'b0;
        start = 1'b0;
        model_on = 1'b0;
        busy_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ld_d(input logic [7:0] v);
        ld_data_valid = 1'b1;
        ld_data = v;
        @(posedge clk);
        #1;
        ld_data_valid = 1'b0;
    endtask

    task automatic ld_c(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
        ld_cmd_valid = 1'b1;
        ld_cmd = c;
        ld_index = i;
        ld_value = v;
        @(posedge clk);
        #1;
        ld_cmd_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!seq_done && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(seq_done), 32'd1);
    endtask

    initial begin
        int db, cb, vb, n;
        logic seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_seq_busy", 32'(seq_busy), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_cv", 32'(cmd_valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        rst = 1'b0;

        // Stream 3,9,1,7 while busy is high; busy drops after the last beat
        do_reset();
        ld_d(8'd3); ld_d(8'd9); ld_d(8'd1); ld_d(8'd7);
        busy_man = 1'b1;
        db = dlog.size();
        cb = clog_c.size();
        go();
        check("t1_seq_busy", 32'(seq_busy), 32'd1);
        seen = 1'b0;
        n = 0;
        while (!(seen && !data_valid) && n < 20) begin
            if (data_valid) seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_dv_fell", 32'(seen && !data_valid), 32'd1);
        busy_man = 1'b0;
        wait_done("t1_done", 10);
        check("t1_nbeats", 32'(dlog.size() - db), 32'd4);
        if (dlog.size() - db == 4) begin
            check("t1_d0", 32'(dlog[db]), 32'd3);
            check("t1_d1", 32'(dlog[db+1]), 32'd9);
            check("t1_d2", 32'(dlog[db+2]), 32'd1);
            check("t1_d3", 32'(dlog[db+3]), 32'd7);
            check("t1_contig", 32'(dcyc[db+3] - dcyc[db]), 32'd3);
        end
        check("t1_ncmd", 32'(clog_c.size() - cb), 32'd0);
        check("t1_ld_ready", 32'(ld_ready), 32'd0);
        go();
        check("t1_fin_hold", 32'(seq_done), 32'd1);

        // Commands {0},{4}, busy pulses one cycle per command; simultaneous and start-cycle writes
        do_reset();
        model_on = 1'b1;
        hold_len = 1;
        ld_data_valid = 1'b1; ld_data = 8'd5;
        ld_cmd_valid = 1'b1; ld_cmd = 3'd0; ld_index = 8'd0; ld_value = 8'd0;
        @(posedge clk);
        #1;
        ld_data_valid = 1'b0;
        ld_cmd = 3'd4;
        db = dlog.size();
        cb = clog_c.size();
        go();
        ld_cmd_valid = 1'b0;
        wait_done("t2_done", 40);
        check("t2_nbeats", 32'(dlog.size() - db), 32'd1);
        if (dlog.size() - db == 1) check("t2_d0", 32'(dlog[db]), 32'd5);
        check("t2_ncmd", 32'(clog_c.size() - cb), 32'd2);
        if (clog_c.size() - cb == 2) begin
            check("t2_c0", 32'(clog_c[cb]), 32'd0);
            check("t2_c1", 32'(clog_c[cb+1]), 32'd4);
        end
        check("t2_err", 32'(err_flags), 32'd0);

        // Commands {2,2,20},{1},{4} with busy held five cycles after each accept
        do_reset();
        model_on = 1'b1;
        hold_len = 5;
        ld_c(3'd2, 8'd2, 8'd20);
        ld_c(3'd1, 8'd0, 8'd0);
        ld_c(3'd4, 8'd0, 8'd0);
        cb = clog_c.size();
        vb = viol;
        go();
        wait_done("t3_done", 100);
        check("t3_ncmd", 32'(clog_c.size() - cb), 32'd3);
        if (clog_c.size() - cb == 3) begin
            check("t3_c0", 32'(clog_c[cb]), 32'd2);
            check("t3_i0", 32'(clog_i[cb]), 32'd2);
            check("t3_v0", 32'(clog_v[cb]), 32'd20);
            check("t3_c1", 32'(clog_c[cb+1]), 32'd1);
            check("t3_c2", 32'(clog_c[cb+2]), 32'd4);
        end
        check("t3_no_strobe_in_busy", 32'(viol - vb), 32'd0);
        check("t3_cmd_hold", 32'(cmd), 32'd4);

        // Data overflow at depth 4
        do_reset();
        ld_d(8'd10); ld_d(8'd11); ld_d(8'd12); ld_d(8'd13); ld_d(8'd14);
        check("t4_err", 32'(err_flags), 32'd1);
        db = dlog.size();
        go();
        wait_done("t4_done", 20);
        check("t4_nbeats", 32'(dlog.size() - db), 32'd4);
        if (dlog.size() - db == 4) begin
            check("t4_d0", 32'(dlog[db]), 32'd10);
            check("t4_d3", 32'(dlog[db+3]), 32'd13);
        end

        // write_RAM first: later commands are never issued
        do_reset();
        model_on = 1'b1;
        hold_len = 2;
        ld_c(3'd4, 8'd0, 8'd0);
        ld_c(3'd1, 8'd0, 8'd0);
        cb = clog_c.size();
        go();
        wait_done("t5_done", 40);
        repeat (5) @(posedge clk);
        #1;
        check("t5_ncmd", 32'(clog_c.size() - cb), 32'd1);
        if (clog_c.size() - cb >= 1) check("t5_c0", 32'(clog_c[cb]), 32'd4);

        // Command overflow, then reset during STREAM
        do_reset();
        for (int k = 0; k < 5; k++) ld_c(3'd7, 8'(k), 8'(k));
        check("t6_err", 32'(err_flags), 32'd2);
        do_reset();
        ld_d(8'd1); ld_d(8'd2); ld_d(8'd3); ld_d(8'd4);
        go();
        check("t6_dv_stream", 32'(data_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_dv", 32'(data_valid), 32'd0);
        check("t6_rst_sbusy", 32'(seq_busy), 32'd0);
        check("t6_rst_ldrdy", 32'(ld_ready), 32'd1);
        check("t6_rst_data", 32'(data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        db = dlog.size();
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_more_beats", 32'(dlog.size() - db), 32'd0);

        // busy stuck high in WAIT_RDY
        do_reset();
        busy_man = 1'b1;
        go();
`ifdef MPQ_SEQ_TIMEOUT_EN
        repeat (7) @(posedge clk);
        #1;
        check("t7_before_tmo", 32'(seq_done), 32'd0);
        @(posedge clk);
        #1;
        check("t7_tmo_done", 32'(seq_done), 32'd1);
        check("t7_tmo_err", 32'(err_flags), 32'd4);
`else
        repeat (20) @(posedge clk);
        #1;
        check("t7_waiting", 32'(seq_done), 32'd0);
        check("t7_sbusy", 32'(seq_busy), 32'd1);
        check("t7_err", 32'(err_flags), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
